// File: rtl/alu_datapath.sv
// Multi-cycle 8-bit ALU datapath: single-cycle logic/arith ops plus an
// 8-iteration shift-add multiplier and restoring divider, one op per request.
module alu_datapath #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned OP_W  = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [OP_W-1:0]  opcode,
  input  logic [7:0]       a,
  input  logic [7:0]       b,
  output logic             done,
  output logic             busy,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             zero,
  output logic             div_by_zero,
  output logic             invalid_opcode
);

  localparam int unsigned CNT_W = 4;
  localparam int unsigned PW    = 16;
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(7);

  localparam logic [OP_W-1:0] OP_ADD  = OP_W'(0);
  localparam logic [OP_W-1:0] OP_SUB  = OP_W'(1);
  localparam logic [OP_W-1:0] OP_AND  = OP_W'(2);
  localparam logic [OP_W-1:0] OP_OR   = OP_W'(3);
  localparam logic [OP_W-1:0] OP_XOR  = OP_W'(4);
  localparam logic [OP_W-1:0] OP_NOT  = OP_W'(5);
  localparam logic [OP_W-1:0] OP_SHL  = OP_W'(6);
  localparam logic [OP_W-1:0] OP_SHR  = OP_W'(7);
  localparam logic [OP_W-1:0] OP_MUL  = OP_W'(8);
  localparam logic [OP_W-1:0] OP_DIV  = OP_W'(9);
  localparam logic [OP_W-1:0] OP_MOD  = OP_W'(10);
  localparam logic [OP_W-1:0] OP_PASS = OP_W'(11);
  localparam logic [OP_W-1:0] OP_HALT = OP_W'(15);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ITER = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [OP_W-1:0]   op_q, op_d;
  logic [PW-1:0]     acc_q, acc_d;   // MUL accumulator / DIV partial remainder
  logic [PW-1:0]     sh_q, sh_d;     // MUL shifted multiplicand / DIV dividend->quotient
  logic [7:0]        opb_q, opb_d;   // MUL multiplier (shifts) / DIV divisor (static)

  logic             done_d, busy_d, carry_d, zero_d, dbz_d, inv_d;
  logic [WIDTH-1:0] result_d;

  logic             wr;
  logic [WIDTH-1:0] res_v;
  logic             carry_v;
  logic [8:0]       sum9, diff9, trial;
  logic             fits;
  logic [7:0]       not_a, shr_a;
  logic [PW-1:0]    shl_a;

  // State register and all registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= S_IDLE;
      cnt_q          <= '0;
      op_q           <= '0;
      acc_q          <= '0;
      sh_q           <= '0;
      opb_q          <= '0;
      done           <= 1'b0;
      busy           <= 1'b0;
      result         <= '0;
      carry          <= 1'b0;
      zero           <= 1'b0;
      div_by_zero    <= 1'b0;
      invalid_opcode <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      op_q           <= op_d;
      acc_q          <= acc_d;
      sh_q           <= sh_d;
      opb_q          <= opb_d;
      done           <= done_d;
      busy           <= busy_d;
      result         <= result_d;
      carry          <= carry_d;
      zero           <= zero_d;
      div_by_zero    <= dbz_d;
      invalid_opcode <= inv_d;
    end
  end

  // Next-state, sequencer and output-update logic
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    acc_d    = acc_q;
    sh_d     = sh_q;
    opb_d    = opb_q;
    done_d   = 1'b0;
    busy_d   = busy;
    result_d = result;
    carry_d  = carry;
    zero_d   = zero;
    dbz_d    = div_by_zero;
    inv_d    = invalid_opcode;
    wr       = 1'b0;
    res_v    = '0;
    carry_v  = 1'b0;

    sum9  = {1'b0, a} + {1'b0, b};
    diff9 = {1'b0, a} - {1'b0, b};
    not_a = ~a;
    shr_a = a >> b[2:0];
    shl_a = {8'h00, a} << b[3:0];
    trial = {acc_q[7:0], sh_q[7]};
    fits  = (trial >= {1'b0, opb_q});

    unique case (state_q)
      S_IDLE: begin
        if (enable) begin
          busy_d  = 1'b1;
          dbz_d   = 1'b0;
          inv_d   = 1'b0;
          op_d    = opcode;
          state_d = S_DONE;
          done_d  = 1'b1;
          case (opcode)
            OP_ADD: begin
              wr      = 1'b1;
              res_v   = WIDTH'(sum9);
              carry_v = sum9[8];
            end
            OP_SUB: begin
              // borrow out of the 9-bit difference doubles as the sign bit
              wr      = 1'b1;
              res_v   = {{(WIDTH-9){diff9[8]}}, diff9};
              carry_v = diff9[8];
            end
            OP_AND:  begin wr = 1'b1; res_v = WIDTH'(a & b); end
            OP_OR:   begin wr = 1'b1; res_v = WIDTH'(a | b); end
            OP_XOR:  begin wr = 1'b1; res_v = WIDTH'(a ^ b); end
            OP_NOT:  begin wr = 1'b1; res_v = WIDTH'(not_a); end
            OP_SHL:  begin wr = 1'b1; res_v = WIDTH'(shl_a); end
            OP_SHR:  begin wr = 1'b1; res_v = WIDTH'(shr_a); end
            OP_PASS: begin wr = 1'b1; res_v = WIDTH'(a); end
            OP_MUL: begin
              state_d = S_ITER;
              done_d  = 1'b0;
              cnt_d   = '0;
              acc_d   = '0;
              sh_d    = {8'h00, a};
              opb_d   = b;
            end
            OP_DIV, OP_MOD: begin
              if (b == 8'h00) begin
                wr    = 1'b1;
                res_v = (opcode == OP_DIV) ? WIDTH'(8'hFF) : WIDTH'(a);
                dbz_d = 1'b1;
              end else begin
                state_d = S_ITER;
                done_d  = 1'b0;
                cnt_d   = '0;
                acc_d   = '0;
                sh_d    = {8'h00, a};
                opb_d   = b;
              end
            end
            OP_HALT: ;
            default: inv_d = 1'b1;
          endcase
        end
      end

      S_ITER: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (op_q == OP_MUL) begin
          acc_d = opb_q[0] ? (acc_q + sh_q) : acc_q;
          sh_d  = sh_q << 1;
          opb_d = opb_q >> 1;
          res_v = WIDTH'(acc_d);
        end else begin
          // restoring division, one dividend bit per cycle from the MSB
          acc_d = {8'h00, (fits ? 8'(trial - {1'b0, opb_q}) : trial[7:0])};
          sh_d  = {8'h00, sh_q[6:0], fits};
          res_v = (op_q == OP_DIV) ? WIDTH'(sh_d[7:0]) : WIDTH'(acc_d[7:0]);
        end
        if (cnt_q == LAST_ITER) begin
          wr      = 1'b1;
          state_d = S_DONE;
          done_d  = 1'b1;
          cnt_d   = '0;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end

      default: state_d = S_IDLE;
    endcase

    if (wr) begin
      result_d = res_v;
      carry_d  = carry_v;
      zero_d   = (res_v == '0);
    end
  end

endmodule
